// File: rtl/mips_hazard_scoreboard_if.sv
// Decode-stage <-> hazard scoreboard bundle: issue fields, pipeline control,
// and the stall/forwarding selects returned to decode.
interface mips_hazard_scoreboard_if #(
    parameter int RA_W  = 5,
    parameter int SEL_W = 2
);
    logic             issue_valid;
    logic [RA_W-1:0]  issue_rs;
    logic [RA_W-1:0]  issue_rt;
    logic             issue_use_rs;
    logic             issue_use_rt;
    logic             issue_wr;
    logic [RA_W-1:0]  issue_rd;
    logic [SEL_W-1:0] issue_rdy;
    logic             hold;
    logic             flush;
    logic [SEL_W-1:0] flush_upto;
    logic             stall;
    logic [SEL_W-1:0] fwd_rs;
    logic [SEL_W-1:0] fwd_rt;
    logic [15:0]      stall_cnt;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
               issue_wr, issue_rd, issue_rdy, hold, flush, flush_upto,
        input  stall, fwd_rs, fwd_rt, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
               issue_wr, issue_rd, issue_rdy, hold, flush, flush_upto,
        output stall, fwd_rs, fwd_rt, stall_cnt
    );
endinterface

// File: rtl/mips_hazard_scoreboard.sv
// Shadow pipeline of in-flight destinations producing decode stall and forwarding selects.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module mips_hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5,
    parameter int SEL_W = 2
) (
    input  logic clk,
    input  logic rst,
    mips_hazard_scoreboard_if.slave sb
);

    logic             vld_p [1:DEPTH];
    logic [RA_W-1:0]  rd_p  [1:DEPTH];
    logic [SEL_W-1:0] rdy_p [1:DEPTH];

    logic             hit_rs, hit_rt;
    logic [SEL_W-1:0] k_rs, k_rt;
    logic [SEL_W-1:0] rdy_rs, rdy_rt;
    logic             act_rs, act_rt;
    logic             haz_rs, haz_rt;
    logic             stall_w;

    // Walk oldest to youngest so the youngest matching stage is the one left standing.
    always_comb begin
        hit_rs = 1'b0;
        k_rs   = '0;
        rdy_rs = '0;
        hit_rt = 1'b0;
        k_rt   = '0;
        rdy_rt = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (vld_p[k] && (rd_p[k] == sb.issue_rs)) begin
                hit_rs = 1'b1;
                k_rs   = SEL_W'(k);
                rdy_rs = rdy_p[k];
            end
            if (vld_p[k] && (rd_p[k] == sb.issue_rt)) begin
                hit_rt = 1'b1;
                k_rt   = SEL_W'(k);
                rdy_rt = rdy_p[k];
            end
        end
    end

    assign act_rs  = sb.issue_valid && sb.issue_use_rs && (sb.issue_rs != '0);
    assign act_rt  = sb.issue_valid && sb.issue_use_rt && (sb.issue_rt != '0);
    assign haz_rs  = act_rs && hit_rs && (k_rs < rdy_rs);
    assign haz_rt  = act_rt && hit_rt && (k_rt < rdy_rt);
    assign stall_w = haz_rs || haz_rt;

    assign sb.stall  = stall_w;
    assign sb.fwd_rs = (act_rs && hit_rs && !haz_rs) ? k_rs : '0;
    assign sb.fwd_rt = (act_rt && hit_rt && !haz_rt) ? k_rt : '0;

    // Stage valids: shift, then kill stages 1..flush_upto (values above DEPTH simply cover all).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= DEPTH; k++) vld_p[k] <= 1'b0;
        end else if (!sb.hold) begin
            for (int k = DEPTH; k >= 2; k--)
                vld_p[k] <= vld_p[k-1] && !(sb.flush && (k <= int'(sb.flush_upto)));
            vld_p[1] <= sb.issue_valid && sb.issue_wr && (sb.issue_rd != '0) &&
                        !stall_w && !sb.flush;
        end
    end

    // Stage payload; only meaningful where the matching valid is set.
    always_ff @(posedge clk) begin
        if (!sb.hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                rd_p[k]  <= rd_p[k-1];
                rdy_p[k] <= rdy_p[k-1];
            end
            rd_p[1]  <= sb.issue_rd;
            rdy_p[1] <= sb.issue_rdy;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt_q <= '0;
        else if (stall_w && !sb.hold)
            stall_cnt_q <= sat_inc(stall_cnt_q);
    end

    assign sb.stall_cnt = stall_cnt_q;
`else
    assign sb.stall_cnt = '0;
`endif

endmodule
